mcycle_unit: RTL and testbench

//   Multi-cycle unsigned multiply/divide engine in the execute stage, beside the ALU.

---
 rtl/mcycle_unit.sv | 142 ++++++++++++++
 tb/tb_mcycle_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mcycle_unit.sv
// mcycle_unit: multi-cycle unsigned multiply/divide engine for the execute stage.
//
// Radix-2 iterative datapath: one shift-add (MUL) or restoring-subtract (DIV) step per
// clock, WIDTH steps per operation. A request is only taken from IDLE. Results are held
// until the next completion or reset.
//
// Ports
//   CLK       in   1      clock, rising edge
//   nRESET    in   1      asynchronous active-low reset
//   Start     in   1      level request, sampled only in IDLE
//   MCycleOp  in   1      0 = MUL, 1 = DIV, sampled with Start
//   Operand1  in   WIDTH  multiplicand / dividend
//   Operand2  in   WIDTH  multiplier / divisor
//   Result1   out  WIDTH  MUL: product low word; DIV: quotient
//   Result2   out  WIDTH  MUL: product high word; DIV: remainder
//   Busy      out  1      stall request: (IDLE & Start) | COMPUTE
//   Done      out  1      one-cycle pulse, results valid
module mcycle_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              op_q, op_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    // MUL: {hi,lo} = {partial product, remaining multiplier bits}.
    // DIV: {hi,lo} = {partial remainder, dividend bits shifting into quotient}.
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  res1_q, res1_d;
    logic [WIDTH-1:0]  res2_q, res2_d;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic [WIDTH-1:0]  step_hi;
    logic [WIDTH-1:0]  step_lo;

    // One iteration of the selected algorithm.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q) begin
            // Bit WIDTH of the trial difference set means the subtraction went negative.
            step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            // Carry out of the add is kept by shifting it into the top bit.
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    op_d    = MCycleOp;
                    opnd_d  = MCycleOp ? Operand2 : Operand1;
                    lo_d    = MCycleOp ? Operand1 : Operand2;
                    hi_d    = '0;
                    count_d = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                hi_d    = step_hi;
                lo_d    = step_lo;
                count_d = count_q + 1'b1;
                if (count_q == LastIter) begin
                    res1_d  = step_lo;
                    res2_d  = step_hi;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= StIdle;
            count_q <= '0;
            op_q    <= 1'b0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
        end
    end

    assign Result1 = res1_q;
    assign Result2 = res2_q;
    assign Busy    = ((state_q == StIdle) && Start) || (state_q == StCompute);
    assign Done    = (state_q == StDone);

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed self-checking bench for mcycle_unit (WIDTH = 32).
// Cycle 0 is the cycle in which Start is first driven high; inputs change 1 time unit
// after a rising edge, outputs are sampled on the falling edge.
module tb_mcycle_unit;

    logic        CLK;
    logic        nRESET;
    logic        Start;
    logic        MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;

    int n_cmp;
    int n_err;

    mcycle_unit #(
        .WIDTH(32)
    ) dut (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .Start   (Start),
        .MCycleOp(MCycleOp),
        .Operand1(Operand1),
        .Operand2(Operand2),
        .Result1 (Result1),
        .Result2 (Result2),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op in the current cycle (Start dropped after cycle 0) and watch 40 cycles.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2);
        int done_cyc  = -1;
        int n_done    = 0;
        int n_busy    = 0;
        int last_busy = -1;
        logic [31:0] r1_at_done = '0;
        logic [31:0] r2_at_done = '0;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (Done) begin
                n_done++;
                done_cyc   = c;
                r1_at_done = Result1;
                r2_at_done = Result2;
            end
            if (Busy) begin
                n_busy++;
                last_busy = c;
            end
            @(posedge CLK);
            #1;
            if (c == 0) Start = 1'b0;
        end
        check({tag, " done_cycle"}, 64'(done_cyc), 64'd33);
        check({tag, " done_count"}, 64'(n_done), 64'd1);
        check({tag, " busy_count"}, 64'(n_busy), 64'd33);
        check({tag, " busy_last"}, 64'(last_busy), 64'd32);
        check({tag, " r1_at_done"}, {32'd0, r1_at_done}, {32'd0, e1});
        check({tag, " r2_at_done"}, {32'd0, r2_at_done}, {32'd0, e2});
        check({tag, " r1_held"}, {32'd0, Result1}, {32'd0, e1});
        check({tag, " r2_held"}, {32'd0, Result2}, {32'd0, e2});
    endtask

    initial begin
        int n_done;
        int done_a;
        int done_b;
        logic [31:0] r1_a;
        logic [31:0] r1_b;
        logic [31:0] r2_b;
        n_cmp    = 0;
        n_err    = 0;
        nRESET   = 1'b0;
        Start    = 1'b0;
        MCycleOp = 1'b0;
        Operand1 = '0;
        Operand2 = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst busy", 64'(Busy), 64'd0);
        check("rst done", 64'(Done), 64'd0);
        check("rst r1", 64'(Result1), 64'd0);
        check("rst r2", 64'(Result2), 64'd0);
        nRESET = 1'b1;
        @(posedge CLK);
        #1;

        run_op("mul7x6", 1'b0, 32'd7, 32'd6, 32'd42, 32'd0);
        run_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
        run_op("div80_1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
        run_op("div5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

        // Reset in cycle 10 of a MUL: immediate abort, no Done afterwards.
        MCycleOp = 1'b0;
        Operand1 = 32'd123;
        Operand2 = 32'd456;
        Start    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK);
            #1;
            Start = 1'b0;
        end
        check("pre-rst busy", 64'(Busy), 64'd1);
        nRESET = 1'b0;
        #1;
        check("midrst busy", 64'(Busy), 64'd0);
        check("midrst done", 64'(Done), 64'd0);
        check("midrst r1", 64'(Result1), 64'd0);
        check("midrst r2", 64'(Result2), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        nRESET = 1'b1;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (Done) n_done++;
        end
        check("midrst no_done", 64'(n_done), 64'd0);
        @(posedge CLK);
        #1;
        run_op("div9_3", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0);

        // Start held across two ops; Operand1 changes in cycle 5 of op 1.
        MCycleOp = 1'b0;
        Operand1 = 32'd1000;
        Operand2 = 32'd3;
        Start    = 1'b1;
        n_done   = 0;
        done_a   = -1;
        done_b   = -1;
        r1_a     = '0;
        r1_b     = '0;
        r2_b     = '0;
        for (int c = 0; c < 75; c++) begin
            @(negedge CLK);
            if (c == 33) check("hold busy_c33", 64'(Busy), 64'd0);
            if (c == 34) check("hold busy_c34", 64'(Busy), 64'd1);
            if (Done) begin
                n_done++;
                if (done_a < 0) begin
                    done_a = c;
                    r1_a   = Result1;
                end else begin
                    done_b = c;
                    r1_b   = Result1;
                    r2_b   = Result2;
                end
            end
            @(posedge CLK);
            #1;
            if (c == 4) Operand1 = 32'd5;
            if (c == 34) Start = 1'b0;
        end
        check("hold done_count", 64'(n_done), 64'd2);
        check("hold done_a", 64'(done_a), 64'd33);
        check("hold done_b", 64'(done_b), 64'd67);
        check("hold r1_op1", 64'(r1_a), 64'd3000);
        check("hold r1_op2", 64'(r1_b), 64'd15);
        check("hold r2_op2", 64'(r2_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
